// File: rtl/uart_pkg.sv
// Shared encodings for the UART message sequencer: request types,
// one-hot text strobe positions and per-message lengths.
package uart_pkg;

  typedef enum logic [1:0] {
    MSG_OK     = 2'd0,
    MSG_FAIL   = 2'd1,
    MSG_HEX    = 2'd2,
    MSG_PROMPT = 2'd3
  } msg_t;

  localparam int unsigned TXT_O     = 7;
  localparam int unsigned TXT_K     = 6;
  localparam int unsigned TXT_F     = 5;
  localparam int unsigned TXT_A     = 4;
  localparam int unsigned TXT_I     = 3;
  localparam int unsigned TXT_L     = 2;
  localparam int unsigned TXT_LF    = 1;
  localparam int unsigned TXT_RIGHT = 0;

  localparam logic [2:0] LEN_OK     = 3'd4;
  localparam logic [2:0] LEN_FAIL   = 3'd6;
  localparam logic [2:0] LEN_HEX    = 3'd6;
  localparam logic [2:0] LEN_PROMPT = 3'd1;

  function automatic logic [7:0] txt(input int unsigned b);
    return 8'b1 << b;
  endfunction

  function automatic logic [2:0] len_of(input msg_t t);
    logic [2:0] n;
    unique case (t)
      MSG_OK:   n = LEN_OK;
      MSG_FAIL: n = LEN_FAIL;
      MSG_HEX:  n = LEN_HEX;
      default:  n = LEN_PROMPT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_msg_rom.sv
// Character table: maps (message type, index, data) to the strobe
// that character needs, plus a flag marking the final character.
module uart_msg_rom
  import uart_pkg::*;
(
  input  msg_t        mtype,
  input  logic [2:0]  idx,
  input  logic [15:0] data,
  output logic [7:0]  text,
  output logic        num,
  output logic [3:0]  nib,
  output logic        last
);

  always_comb begin
    text = '0;
    num  = 1'b0;
    nib  = '0;
    last = (idx == len_of(mtype) - 3'd1);
    unique case (mtype)
      MSG_OK: begin
        case (idx)
          3'd0:    text = txt(TXT_O);
          3'd1:    text = txt(TXT_K);
          3'd2:    text = txt(TXT_LF);
          default: text = txt(TXT_RIGHT);
        endcase
      end
      MSG_FAIL: begin
        case (idx)
          3'd0:    text = txt(TXT_F);
          3'd1:    text = txt(TXT_A);
          3'd2:    text = txt(TXT_I);
          3'd3:    text = txt(TXT_L);
          3'd4:    text = txt(TXT_LF);
          default: text = txt(TXT_RIGHT);
        endcase
      end
      MSG_HEX: begin
        case (idx)
          3'd0: begin
            num = 1'b1;
            nib = data[15:12];
          end
          3'd1: begin
            num = 1'b1;
            nib = data[11:8];
          end
          3'd2: begin
            num = 1'b1;
            nib = data[7:4];
          end
          3'd3: begin
            num = 1'b1;
            nib = data[3:0];
          end
          3'd4:    text = txt(TXT_LF);
          default: text = txt(TXT_RIGHT);
        endcase
      end
      default: text = txt(TXT_RIGHT);
    endcase
  end

endmodule

// File: rtl/uart_msg_seq.sv
// Message sequencer: issues one encoder strobe per character and
// waits for TX_DONE between characters, aborting on a watchdog.
module uart_msg_seq
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        CLK_100M,
  input  logic        SYS_RST,
  input  logic        REQ_VALID,
  input  logic [1:0]  REQ_TYPE,
  input  logic [15:0] REQ_DATA,
  output logic        REQ_READY,
  input  logic        TX_DONE,
  output logic [7:0]  SEQ_TEXT,
  output logic        SEQ_NUM,
  output logic [3:0]  SEQ_DBACK,
  output logic        SEQ_BUSY,
  output logic        SEQ_ERR
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } st_t;

  st_t           state, nxt;
  msg_t          mtype, ty_n;
  logic [15:0]   data, dt_n;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          last_q, err_n;
  logic [7:0]    r_text;
  logic          r_num, r_last;
  logic [3:0]    r_nib;

  assign REQ_READY = (state == IDLE);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    nxt   = state;
    idx_n = idx;
    cnt_n = cnt;
    ty_n  = mtype;
    dt_n  = data;
    err_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (REQ_VALID) begin
          ty_n  = msg_t'(REQ_TYPE);
          dt_n  = REQ_DATA;
          idx_n = '0;
          nxt   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n = '0;
        nxt   = WAIT;
      end
      WAIT: begin
        cnt_n = cnt_inc;
        if (TX_DONE) begin
          if (last_q) begin
            nxt = IDLE;
          end else begin
            idx_n = idx + 3'd1;
            nxt   = ISSUE;
          end
        end else if (cnt_inc == TMAX) begin
          nxt   = IDLE;
          err_n = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Looked up with next-cycle values so the strobe can be registered
  uart_msg_rom u_rom (
    .mtype (ty_n),
    .idx   (idx_n),
    .data  (dt_n),
    .text  (r_text),
    .num   (r_num),
    .nib   (r_nib),
    .last  (r_last)
  );

  always_ff @(posedge CLK_100M or posedge SYS_RST) begin
    if (SYS_RST) begin
      state     <= IDLE;
      mtype     <= MSG_OK;
      data      <= '0;
      idx       <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      SEQ_TEXT  <= '0;
      SEQ_NUM   <= 1'b0;
      SEQ_DBACK <= '0;
      SEQ_BUSY  <= 1'b0;
      SEQ_ERR   <= 1'b0;
    end else begin
      state    <= nxt;
      mtype    <= ty_n;
      data     <= dt_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      SEQ_BUSY <= (nxt != IDLE);
      SEQ_ERR  <= err_n;
      if (nxt == ISSUE) begin
        SEQ_TEXT  <= r_text;
        SEQ_NUM   <= r_num;
        SEQ_DBACK <= r_num ? r_nib : 4'd0;
        last_q    <= r_last;
      end else begin
        SEQ_TEXT  <= '0;
        SEQ_NUM   <= 1'b0;
        SEQ_DBACK <= '0;
      end
    end
  end

endmodule

// File: doc/uart_msg_seq.md
# uart_msg_seq

Message sequencer in front of the UART text/number encoder. It accepts one message request at a time: OK, FAIL, a 16-bit hex value, or a bare prompt. It issues the message character by character as single-cycle encoder strobes, waiting for the UART transmitter's byte-done pulse between characters. A watchdog aborts a message if the transmitter stops answering.

## Interface
Parameters:
- TIMEOUT_CYC, 200000: maximum cycles to wait for TX_DONE after a strobe. This exceeds one 10-bit frame at 9600 baud on 100 MHz.

Ports:
- CLK_100M  in  1  clock
- SYS_RST  in  1  reset, asynchronous, active-high
- REQ_VALID  in  1  request present
- REQ_TYPE  in  2  0=OK, 1=FAIL, 2=HEX, 3=PROMPT
- REQ_DATA  in  16  hex value, used only for HEX
- REQ_READY  out  1  high while idle; request accepted when REQ_VALID && REQ_READY
- TX_DONE  in  1  single-cycle pulse from the UART transmitter when a byte finishes
- SEQ_TEXT  out  8  one-hot text strobe to the encoder: [7]'O' [6]'K' [5]'F' [4]'A' [3]'I' [2]'L' [1]LF [0]'>'
- SEQ_NUM  out  1  digit strobe to the encoder
- SEQ_DBACK  out  4  nibble accompanying SEQ_NUM; 0 when SEQ_NUM is low
- SEQ_BUSY  out  1  message in progress (state != IDLE)
- SEQ_ERR  out  1  single-cycle pulse on watchdog abort

## Operation
- Messages, in issue order:
  - OK: O, K, LF, '>' (4 characters)
  - FAIL: F, A, I, L, LF, '>' (6 characters)
  - HEX: digits REQ_DATA[15:12], [11:8], [7:4], [3:0], then LF, '>' (6 characters)
  - PROMPT: '>' (1 character)
- On acceptance, REQ_TYPE and REQ_DATA are latched. Later changes on the inputs have no effect until the next acceptance.
- FSM states:
  - IDLE: REQ_READY=1. On acceptance, idx←0 and go to ISSUE.
  - ISSUE: exactly one cycle. Exactly one strobe is high: one SEQ_TEXT bit, or SEQ_NUM with SEQ_DBACK. Go to WAIT with the watchdog counter cleared.
  - WAIT:
    - TX_DONE while idx is the last index: go to IDLE.
    - TX_DONE otherwise: idx←idx+1 and go to ISSUE.
    - Counter reaches TIMEOUT_CYC-1 without TX_DONE: go to IDLE, pulse SEQ_ERR, discard the rest of the message.
- TX_DONE in IDLE or ISSUE is ignored; it is not counted for a later character.
- TX_DONE in the same cycle as the timeout: TX_DONE wins and SEQ_ERR is not pulsed.
- Width rules:
  - idx is 3 bits, range 0..5.
  - Watchdog counter width is $clog2(TIMEOUT_CYC); it saturates and does not wrap.
- At most one bit of {SEQ_TEXT, SEQ_NUM} is high in any cycle. All strobe outputs are 0 outside ISSUE.
- SYS_RST mid-message: immediate return to IDLE with all outputs at reset values. No partial character is re-issued.

## Timing
- Reset values:
  - REQ_READY=1
  - SEQ_TEXT=0, SEQ_NUM=0, SEQ_DBACK=0
  - SEQ_BUSY=0, SEQ_ERR=0
  - idx=0, counter=0
- All outputs except REQ_READY are registered. REQ_READY decodes directly from the state register.
- Handshake sampled at clock edge k: first strobe is high in cycle k+1 and REQ_READY goes low in cycle k+1.
- TX_DONE sampled at edge m in WAIT: the next strobe is high in cycle m+1.
- After the last TX_DONE, REQ_READY returns high in the next cycle. Back-to-back messages are therefore separated by one IDLE cycle.
- The encoder adds one register stage, so its start output follows each strobe by one cycle.
- Worst-case abort: SEQ_ERR is high in cycle TIMEOUT_CYC after the ISSUE cycle.

## Structure
- Shared package uart_pkg holds:
  - REQ_TYPE encodings (MSG_OK, MSG_FAIL, MSG_HEX, MSG_PROMPT)
  - one-hot text bit positions (TXT_O … TXT_RIGHT)
  - per-type message lengths (LEN_OK=4, LEN_FAIL=6, LEN_HEX=6, LEN_PROMPT=1)
- Sub-module uart_msg_rom is purely combinational and table-style:
  - inputs: latched type, idx, latched data
  - outputs: text one-hot, num flag, nibble, last flag
- The FSM, watchdog and output registers stay in uart_msg_seq.

## Test plan
- Reset then OK, TX_DONE 20 cycles after each strobe: strobes SEQ_TEXT=0x80, 0x40, 0x02, 0x01 in order; REQ_READY low for the whole message and back high one cycle after the 4th TX_DONE.
- HEX with REQ_DATA=0xA5F0: SEQ_NUM strobes with DBACK=A, 5, F, 0, then 0x02, then 0x01. Changing REQ_DATA mid-message leaves the sequence unchanged.
- FAIL with TX_DONE also pulsed in the ISSUE cycle and in IDLE: those pulses are ignored; exactly 6 strobes, each issued only after a WAIT-state TX_DONE.
- Timeout, TIMEOUT_CYC=50, PROMPT with no TX_DONE: SEQ_ERR pulses once, 50 cycles after the strobe; FSM in IDLE; no further strobes.
- TX_DONE coincident with the timeout cycle: SEQ_ERR stays 0 and the message continues.
- SYS_RST asserted during WAIT of the 3rd HEX character: all outputs go to 0 and REQ_READY to 1 immediately; the next OK request runs cleanly from 'O'.
